// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and constants for the lfsr64 sequencer/arbiter.
//   lfsr_state_t      : controller FSM state encoding
//   LFSR_W            : LFSR datapath width
//   LFSR_DEFAULT_SEED : seed substituted for an all-zero seed
package lfsr_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, WARM, SERVE} lfsr_state_t;

  localparam int LFSR_W = 64;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 64'hACE1_0000_0000_0001;

endpackage

// File: rtl/lfsr_ctrl_arb.sv
// rr_arbiter: round-robin arbiter with a rotating priority pointer.
//   clk     : clock, rising edge
//   reset   : synchronous, active-low; pointer returns to index 0
//   req     : per-requester request
//   advance : a grant is being taken this cycle; pointer moves past the winner
//   gnt     : combinational one-hot winner (all zero when req is zero)
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] idx;
  logic          found;

  // Search starts at ptr, which always holds the index after the last winner.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

endmodule

// File: rtl/lfsr_ctrl.sv
// lfsr_ctrl: seeds one lfsr64 instance, runs a warm-up burst, then shares the
// LFSR among NREQ requesters, one 64-bit word per grant.
//   clk, reset          : clock and synchronous active-low reset
//   seed_in, seed_load  : seed value and (re)seed pulse
//   req / gnt           : level requests, registered one-hot grant pulse
//   rnd_out, rnd_valid  : word handed to the granted requester
//   ready               : controller is serving requests
//   lfsr_load, lfsr_seed, lfsr_en, lfsr_q : lfsr64 interface
//   lockup              : present only with LFSR_LOCKUP_DET_EN defined; pulses
//                         when a zero LFSR state is caught, which forces a reseed
//
// state | meaning
// IDLE  | waiting for seed_load
// LOAD  | lfsr_load asserted, seed (or default) presented to lfsr64
// WARM  | stepping lfsr64 WARMUP times, no grants
// SERVE | ready; round-robin grants, one LFSR step per grant
module lfsr_ctrl
  import lfsr_pkg::*;
#(
  parameter int                NREQ         = 4,
  parameter int                WARMUP       = 16,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              seed_load,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic [LFSR_W-1:0] rnd_out,
  output logic              rnd_valid,
  output logic              ready,
  output logic              lfsr_load,
  output logic [LFSR_W-1:0] lfsr_seed,
  output logic              lfsr_en,
  input  logic [LFSR_W-1:0] lfsr_q
`ifdef LFSR_LOCKUP_DET_EN
  ,
  output logic              lockup
`endif
);

  localparam logic [7:0] WARM_LAST = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);

  lfsr_state_t       state;
  logic [7:0]        warm_cnt;
  logic [LFSR_W-1:0] seed_reg;
  logic [NREQ-1:0]   arb_gnt;
  logic              grant_now;
  logic              lock_now;

`ifdef LFSR_LOCKUP_DET_EN
  assign lock_now = (state == SERVE) && (lfsr_q == '0) && !seed_load;
`else
  assign lock_now = 1'b0;
`endif

  // seed_load and a detected lockup both pre-empt any grant this cycle.
  assign grant_now = reset && (state == SERVE) && !seed_load && !lock_now && (|req);

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (grant_now),
    .gnt     (arb_gnt)
  );

  // The LFSR steps in the grant-decision cycle so a back-to-back grant
  // latches a fresh word on the following edge.
  assign ready     = (state == SERVE);
  assign lfsr_load = (state == LOAD);
  assign lfsr_en   = (state == WARM) || grant_now;
  assign lfsr_seed = lfsr_load ? ((seed_reg == '0) ? DEFAULT_SEED : seed_reg) : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      warm_cnt  <= '0;
      seed_reg  <= '0;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_out   <= '0;
`ifdef LFSR_LOCKUP_DET_EN
      lockup    <= 1'b0;
`endif
    end else begin
      gnt       <= grant_now ? arb_gnt : '0;
      rnd_valid <= grant_now;
      if (grant_now) rnd_out <= lfsr_q;
`ifdef LFSR_LOCKUP_DET_EN
      lockup    <= lock_now;
`endif
      if (seed_load) begin
        state    <= LOAD;
        seed_reg <= seed_in;
        warm_cnt <= '0;
      end else begin
        case (state)
          IDLE:  state <= IDLE;
          LOAD: begin
            warm_cnt <= '0;
            state    <= (WARMUP == 0) ? SERVE : WARM;
          end
          WARM: begin
            if (warm_cnt == WARM_LAST) begin
              warm_cnt <= '0;
              state    <= SERVE;
            end else begin
              warm_cnt <= warm_cnt + 8'd1;
            end
          end
          SERVE: begin
            // A zeroed seed register makes the LOAD state present DEFAULT_SEED.
            if (lock_now) begin
              seed_reg <= '0;
              state    <= LOAD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_ctrl.sv
// tb_lfsr_ctrl: self-checking bench for lfsr_ctrl with a behavioural lfsr64
// attached to the LFSR interface. Inputs driven and outputs sampled on the
// falling edge; expected grants/words are queued and popped on rnd_valid.
module tb_lfsr_ctrl;
  import lfsr_pkg::*;

  localparam int NREQ   = 4;
  localparam int WARMUP = 16;

  typedef struct packed {
    logic [NREQ-1:0] g;
    logic [63:0]     w;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [63:0]     seed_in = '0;
  logic            seed_load = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] gnt;
  logic [63:0]     rnd_out;
  logic            rnd_valid;
  logic            ready;
  logic            lfsr_load;
  logic [63:0]     lfsr_seed;
  logic            lfsr_en;
  logic [63:0]     lfsr_q;
  logic            lockup;
  logic [63:0]     mq = '0;
  logic            force_zero = 1'b0;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t e;
  logic [63:0] exp_q;

`ifndef LFSR_LOCKUP_DET_EN
  assign lockup = 1'b0;
`endif

  lfsr_ctrl #(.NREQ(NREQ), .WARMUP(WARMUP), .DEFAULT_SEED(LFSR_DEFAULT_SEED)) dut (
    .clk       (clk),
    .reset     (reset),
    .seed_in   (seed_in),
    .seed_load (seed_load),
    .req       (req),
    .gnt       (gnt),
    .rnd_out   (rnd_out),
    .rnd_valid (rnd_valid),
    .ready     (ready),
    .lfsr_load (lfsr_load),
    .lfsr_seed (lfsr_seed),
    .lfsr_en   (lfsr_en),
`ifdef LFSR_LOCKUP_DET_EN
    .lockup    (lockup),
`endif
    .lfsr_q    (lfsr_q)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] lfsr_step(input logic [63:0] q);
    return {q[62:0], q[63] ^ q[62] ^ q[60] ^ q[59]};
  endfunction

  function automatic logic [63:0] warm_of(input logic [63:0] s);
    logic [63:0] q = s;
    for (int i = 0; i < WARMUP; i++) q = lfsr_step(q);
    return q;
  endfunction

  // Behavioural lfsr64: q follows load/en one cycle later.
  always @(posedge clk) begin
    if (lfsr_load)    mq <= lfsr_seed;
    else if (lfsr_en) mq <= lfsr_step(mq);
  end
  assign lfsr_q = force_zero ? '0 : mq;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_warm(output int n_en, output int n_load, output bit got_ready);
    n_en = 0; n_load = 0; got_ready = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (ready) begin
        got_ready = 1'b1;
        break;
      end
      if (lfsr_en)   n_en++;
      if (lfsr_load) n_load++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; seed_load = 1'b0; req = '0;
    repeat (2) tick();
    n_tests++; if (gnt !== '0)       begin n_fail++; $display("FAIL rst_gnt: got %b want 0", gnt); end
    n_tests++; if (rnd_valid !== 0)  begin n_fail++; $display("FAIL rst_valid: got %b want 0", rnd_valid); end
    n_tests++; if (ready !== 0)      begin n_fail++; $display("FAIL rst_ready: got %b want 0", ready); end
    n_tests++; if (lfsr_load !== 0)  begin n_fail++; $display("FAIL rst_load: got %b want 0", lfsr_load); end
    n_tests++; if (lfsr_en !== 0)    begin n_fail++; $display("FAIL rst_en: got %b want 0", lfsr_en); end
    n_tests++; if (rnd_out !== '0)   begin n_fail++; $display("FAIL rst_rnd: got %h want 0", rnd_out); end
    n_tests++; if (lockup !== 0)     begin n_fail++; $display("FAIL rst_lockup: got %b want 0", lockup); end
    reset = 1'b1;
    repeat (2) tick();
    n_tests++; if ({ready, lfsr_load, lfsr_en} !== 3'b000) begin n_fail++; $display("FAIL idle_hold: got %b want 000", {ready, lfsr_load, lfsr_en}); end
  endtask

  task automatic test_seed_warm();
    int n_en, n_load; bit ok;
    seed_in = 64'h1; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    n_tests++; if (lfsr_load !== 1)       begin n_fail++; $display("FAIL load_pulse: got %b want 1", lfsr_load); end
    n_tests++; if (lfsr_seed !== 64'h1)   begin n_fail++; $display("FAIL load_seed: got %h want 1", lfsr_seed); end
    n_tests++; if (lfsr_en !== 0)         begin n_fail++; $display("FAIL load_en_excl: got %b want 0", lfsr_en); end
    run_warm(n_en, n_load, ok);
    n_tests++; if (!ok)                   begin n_fail++; $display("FAIL warm_ready: got 0 want 1 (timeout)"); end
    n_tests++; if (n_en != WARMUP)        begin n_fail++; $display("FAIL warm_len: got %0d want %0d", n_en, WARMUP); end
    n_tests++; if (n_load != 0)           begin n_fail++; $display("FAIL warm_reload: got %0d want 0", n_load); end
    exp_q = warm_of(64'h1);
  endtask

  task automatic test_round_robin();
    int got = 0;
    logic [63:0] prev = '0;
    logic [63:0] last_w = '0;
    sb.delete();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      sb.push_back('{g: 4'(1 << (k % 4)), w: exp_q});
      last_w = exp_q;
      exp_q = lfsr_step(exp_q);
    end
    for (int c = 0; c < 20 && got < 5; c++) begin
      tick();
      n_tests++;
      if (!rnd_valid) begin n_fail++; $display("FAIL rr_back_to_back: got valid 0 want 1 at cycle %0d", c); end
      else if (sb.size() == 0) begin n_fail++; $display("FAIL rr_extra: got gnt %b want none", gnt); end
      else begin
        e = sb.pop_front();
        n_tests++; if (gnt !== e.g)     begin n_fail++; $display("FAIL rr_gnt: got %b want %b", gnt, e.g); end
        n_tests++; if (rnd_out !== e.w) begin n_fail++; $display("FAIL rr_word: got %h want %h", rnd_out, e.w); end
        if (got > 0) begin
          n_tests++; if (rnd_out === prev) begin n_fail++; $display("FAIL rr_distinct: got %h want different from %h", rnd_out, prev); end
        end
        prev = rnd_out;
        got++;
      end
    end
    req = '0;
    n_tests++; if (got != 5) begin n_fail++; $display("FAIL rr_count: got %0d want 5", got); end
    tick();
    n_tests++; if ({gnt, rnd_valid} !== 5'b0) begin n_fail++; $display("FAIL idle_gnt: got %b/%b want 0/0", gnt, rnd_valid); end
    n_tests++; if (rnd_out !== last_w) begin n_fail++; $display("FAIL rnd_hold: got %h want %h", rnd_out, last_w); end
  endtask

  task automatic test_zero_seed_precedence();
    int n_en, n_load; bit ok;
    seed_in = '0; seed_load = 1'b1; req = 4'b0010;
    tick();
    seed_load = 1'b0; req = '0;
    n_tests++; if (gnt !== '0)       begin n_fail++; $display("FAIL prec_gnt: got %b want 0", gnt); end
    n_tests++; if (rnd_valid !== 0)  begin n_fail++; $display("FAIL prec_valid: got %b want 0", rnd_valid); end
    n_tests++; if (ready !== 0)      begin n_fail++; $display("FAIL prec_ready: got %b want 0", ready); end
    n_tests++; if (lfsr_load !== 1)  begin n_fail++; $display("FAIL prec_load: got %b want 1", lfsr_load); end
    n_tests++; if (lfsr_seed !== LFSR_DEFAULT_SEED) begin n_fail++; $display("FAIL zero_seed: got %h want %h", lfsr_seed, LFSR_DEFAULT_SEED); end
    run_warm(n_en, n_load, ok);
    n_tests++; if (!ok || n_en != WARMUP) begin n_fail++; $display("FAIL zs_warm: got %0d steps ready %b want %0d ready 1", n_en, ok, WARMUP); end
    exp_q = warm_of(LFSR_DEFAULT_SEED);
    sb.delete();
    req = 4'b0010;
    sb.push_back('{g: 4'b0010, w: exp_q});
    exp_q = lfsr_step(exp_q);
    tick();
    req = '0;
    n_tests++;
    if (!rnd_valid) begin n_fail++; $display("FAIL zs_grant: got valid 0 want 1"); end
    else begin
      e = sb.pop_front();
      n_tests++; if (gnt !== e.g)     begin n_fail++; $display("FAIL zs_gnt: got %b want %b", gnt, e.g); end
      n_tests++; if (rnd_out !== e.w) begin n_fail++; $display("FAIL zs_word: got %h want %h", rnd_out, e.w); end
    end
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] seq [4] = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
    int got = 0;
    sb.delete();
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{g: seq[k], w: exp_q});
      exp_q = lfsr_step(exp_q);
    end
    for (int c = 0; c < 20 && got < 4; c++) begin
      tick();
      n_tests++;
      if (!rnd_valid) begin n_fail++; $display("FAIL b2b_valid: got 0 want 1 at cycle %0d", c); end
      else begin
        e = sb.pop_front();
        n_tests++; if (gnt !== e.g)     begin n_fail++; $display("FAIL b2b_gnt: got %b want %b", gnt, e.g); end
        n_tests++; if (rnd_out !== e.w) begin n_fail++; $display("FAIL b2b_word: got %h want %h", rnd_out, e.w); end
        got++;
      end
    end
    req = '0;
    n_tests++; if (got != 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", got); end
    tick();
  endtask

  task automatic test_lockup();
`ifdef LFSR_LOCKUP_DET_EN
    int n_en, n_load; bit ok;
    force_zero = 1'b1; req = 4'b0001;
    tick();
    force_zero = 1'b0; req = '0;
    n_tests++; if (lockup !== 1)    begin n_fail++; $display("FAIL lock_pulse: got %b want 1", lockup); end
    n_tests++; if (gnt !== '0)      begin n_fail++; $display("FAIL lock_gnt: got %b want 0", gnt); end
    n_tests++; if (rnd_valid !== 0) begin n_fail++; $display("FAIL lock_valid: got %b want 0", rnd_valid); end
    n_tests++; if (lfsr_load !== 1 || lfsr_seed !== LFSR_DEFAULT_SEED) begin n_fail++; $display("FAIL lock_reload: got %b/%h want 1/%h", lfsr_load, lfsr_seed, LFSR_DEFAULT_SEED); end
    run_warm(n_en, n_load, ok);
    n_tests++; if (!ok || n_en != WARMUP) begin n_fail++; $display("FAIL lock_warm: got %0d steps ready %b want %0d ready 1", n_en, ok, WARMUP); end
    n_tests++; if (lockup !== 0)    begin n_fail++; $display("FAIL lock_clear: got %b want 0", lockup); end
    exp_q = warm_of(LFSR_DEFAULT_SEED);
    sb.delete();
    req = 4'b0001;
    sb.push_back('{g: 4'b0001, w: exp_q});
    exp_q = lfsr_step(exp_q);
    tick();
    req = '0;
    n_tests++;
    if (!rnd_valid) begin n_fail++; $display("FAIL lock_resume: got valid 0 want 1"); end
    else begin
      e = sb.pop_front();
      n_tests++; if (gnt !== e.g || rnd_out !== e.w) begin n_fail++; $display("FAIL lock_word: got %b/%h want %b/%h", gnt, rnd_out, e.g, e.w); end
    end
`else
    // Without lockup detection a zero state is handed out like any other word.
    force_zero = 1'b1; req = 4'b0001;
    tick();
    force_zero = 1'b0; req = '0;
    exp_q = lfsr_step(exp_q);
    n_tests++; if (rnd_valid !== 1 || gnt !== 4'b0001) begin n_fail++; $display("FAIL zero_data_gnt: got %b/%b want 1/0001", rnd_valid, gnt); end
    n_tests++; if (rnd_out !== '0) begin n_fail++; $display("FAIL zero_data_word: got %h want 0", rnd_out); end
`endif
  endtask

  task automatic test_reset_mid_warm();
    int n_en, n_load; bit ok;
    logic [63:0] s = 64'h0123_4567_89AB_CDEF;
    seed_in = s; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    tick();
    repeat (7) tick();
    n_tests++; if (lfsr_en !== 1) begin n_fail++; $display("FAIL mw_in_warm: got %b want 1", lfsr_en); end
    reset = 1'b0;
    tick();
    n_tests++; if ({lfsr_en, lfsr_load, ready} !== 3'b000) begin n_fail++; $display("FAIL mw_reset: got %b want 000", {lfsr_en, lfsr_load, ready}); end
    n_tests++; if (rnd_out !== '0) begin n_fail++; $display("FAIL mw_rnd_clr: got %h want 0", rnd_out); end
    reset = 1'b1;
    tick();
    n_tests++; if ({lfsr_en, lfsr_load} !== 2'b00) begin n_fail++; $display("FAIL mw_idle: got %b want 00", {lfsr_en, lfsr_load}); end
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    n_tests++; if (lfsr_load !== 1 || lfsr_seed !== s) begin n_fail++; $display("FAIL mw_load: got %b/%h want 1/%h", lfsr_load, lfsr_seed, s); end
    run_warm(n_en, n_load, ok);
    n_tests++; if (!ok || n_en != WARMUP) begin n_fail++; $display("FAIL mw_warm: got %0d steps ready %b want %0d ready 1", n_en, ok, WARMUP); end
    exp_q = warm_of(s);
    // Reset returns the rr pointer to 0, so index 0 beats index 3.
    sb.delete();
    req = 4'b1001;
    sb.push_back('{g: 4'b0001, w: exp_q});
    tick();
    req = '0;
    n_tests++;
    if (!rnd_valid) begin n_fail++; $display("FAIL mw_grant: got valid 0 want 1"); end
    else begin
      e = sb.pop_front();
      n_tests++; if (gnt !== e.g)     begin n_fail++; $display("FAIL mw_ptr: got %b want %b", gnt, e.g); end
      n_tests++; if (rnd_out !== e.w) begin n_fail++; $display("FAIL mw_word: got %h want %h", rnd_out, e.w); end
    end
  endtask

  initial begin
    test_reset();
    test_seed_warm();
    test_round_robin();
    test_zero_seed_precedence();
    test_back_to_back();
    test_lockup();
    test_reset_mid_warm();
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
